// File: rtl/calc_result_fifo_pkg.sv
// Shared definitions for the calculator datapath: opcodes, default result
// width and the buffered result entry.
package calc_pkg;

  localparam int SM_WIDTH = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;

  // Entry layout at the default width; other widths use a local equivalent.
  typedef struct packed {
    logic [2:0]          op;
    logic [SM_WIDTH-1:0] res;
    logic                sf;
    logic                zf;
    logic                dzf;
  } calc_entry_t;

endpackage

// File: rtl/calc_result_fifo_if.sv
// Handshake and status bundle between the arithmetic units, the result FIFO
// and its downstream consumer.
interface calc_result_fifo_if #(
  parameter int WIDTH = calc_pkg::SM_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; the sender holds its payload steady until that edge.
  logic                     i_valid;
  logic                     o_ready;
  logic [2:0]               i_op;
  logic [WIDTH-1:0]         i_res;
  logic                     i_DZ;
  logic                     i_Z;
  logic                     o_valid;
  logic                     i_ready;
  logic [2:0]               o_op;
  logic [WIDTH-1:0]         o_res;
  logic                     o_SF;
  logic                     o_ZF;
  logic                     o_DZF;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_sticky_DZ;
  logic                     i_clr_sticky;
  logic [CNT_W-1:0]         o_err_cnt;
  logic                     o_flag_mismatch;

  modport master (
    output i_valid, i_op, i_res, i_DZ, i_Z, i_ready, i_clr_sticky,
    input  o_ready, o_valid, o_op, o_res, o_SF, o_ZF, o_DZF, o_count,
           o_sticky_DZ, o_err_cnt, o_flag_mismatch
  );

  modport slave (
    input  i_valid, i_op, i_res, i_DZ, i_Z, i_ready, i_clr_sticky,
    output o_ready, o_valid, o_op, o_res, o_SF, o_ZF, o_DZF, o_count,
           o_sticky_DZ, o_err_cnt, o_flag_mismatch
  );

endinterface

// File: rtl/calc_result_fifo_sm_canon.sv
// Sign-magnitude canonicaliser: folds negative zero to all-zeros and derives
// the sign and zero flags from the canonical value.
module sm_canon #(
  parameter int WIDTH = calc_pkg::SM_WIDTH
) (
  input  logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_c,
  output logic             sf,
  output logic             zf
);

  always_comb begin
    zf    = (res[WIDTH-2:0] == '0);
    res_c = zf ? '0 : res;
    sf    = zf ? 1'b0 : res[WIDTH-1];
  end

endmodule

// File: rtl/calc_result_fifo.sv
// Registered result FIFO behind the arithmetic units, with sticky
// divide-by-zero tracking and a saturating error counter.
module calc_result_fifo
  import calc_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic i_clk,
  input logic i_rst,
  calc_result_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] res;
    logic             sf;
    logic             zf;
    logic             dzf;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             push, pop;
  logic [WIDTH-1:0] res_c;
  logic             sf_c, zf_c;
  logic             sticky_dz, mismatch;
  logic [CNT_W-1:0] err_cnt;

  sm_canon #(.WIDTH(WIDTH)) u_canon (
    .res   (bus.i_res),
    .res_c (res_c),
    .sf    (sf_c),
    .zf    (zf_c)
  );

  // Occupancy comes straight from the wrap-bit pointers, so ready/valid
  // depend on registered state only.
  assign count       = wr_ptr - rd_ptr;
  assign bus.o_ready = (count != (AW+1)'(DEPTH));
  assign bus.o_valid = (count != '0);
  assign bus.o_count = count;
  assign push        = bus.i_valid & bus.o_ready;
  assign pop         = bus.o_valid & bus.i_ready;

  always_comb begin
    wr_entry.op  = bus.i_op;
    wr_entry.res = res_c;
    wr_entry.sf  = sf_c;
    wr_entry.zf  = zf_c;
    wr_entry.dzf = bus.i_DZ;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A DZ push in the same cycle as a clear wins, restarting the count at 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_dz <= 1'b0;
      err_cnt   <= '0;
      mismatch  <= 1'b0;
    end else begin
      if (push && bus.i_DZ) begin
        sticky_dz <= 1'b1;
        if (bus.i_clr_sticky)  err_cnt <= CNT_W'(1);
        else if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (bus.i_clr_sticky) begin
        sticky_dz <= 1'b0;
        err_cnt   <= '0;
      end
      if (push && (bus.i_Z != zf_c)) mismatch <= 1'b1;
      else if (bus.i_clr_sticky)     mismatch <= 1'b0;
    end
  end

  // Stale storage is hidden while the FIFO is empty.
  always_comb begin
    head = bus.o_valid ? mem[rd_ptr[AW-1:0]] : '0;
  end

  assign bus.o_op            = head.op;
  assign bus.o_res           = head.res;
  assign bus.o_SF            = head.sf;
  assign bus.o_ZF            = head.zf;
  assign bus.o_DZF           = head.dzf;
  assign bus.o_sticky_DZ     = sticky_dz;
  assign bus.o_err_cnt       = err_cnt;
  assign bus.o_flag_mismatch = mismatch;

endmodule

// File: tb/tb_calc_result_fifo.sv
// Directed bench for calc_result_fifo: hand-computed expectations checked
// with immediate assertions after each step.
module tb_calc_result_fifo;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  calc_result_fifo_if #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) bus ();

  calc_result_fifo #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] res,
                       input logic dz, input logic z);
    bus.i_valid = v;
    bus.i_op    = op;
    bus.i_res   = res;
    bus.i_DZ    = dz;
    bus.i_Z     = z;
  endtask

  logic [2:0] exp_q[$];
  logic [2:0] fill_res[5];

  initial begin
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    bus.i_ready      = 1'b0;
    bus.i_clr_sticky = 1'b0;
    fill_res[0] = 3'b001; fill_res[1] = 3'b010; fill_res[2] = 3'b011;
    fill_res[3] = 3'b111; fill_res[4] = 3'b110;

    // Reset and idle
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("rst_valid",    32'(bus.o_valid), 32'd0);
    chk("rst_ready",    32'(bus.o_ready), 32'd1);
    chk("rst_count",    32'(bus.o_count), 32'd0);
    chk("rst_err",      32'(bus.o_err_cnt), 32'd0);
    chk("rst_sticky",   32'(bus.o_sticky_DZ), 32'd0);
    chk("rst_mismatch", 32'(bus.o_flag_mismatch), 32'd0);
    chk("rst_outs",     32'({bus.o_op, bus.o_res, bus.o_SF, bus.o_ZF, bus.o_DZF}), 32'd0);

    // rem result -1
    drive(1'b1, 3'd4, 3'b101, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("neg1_valid", 32'(bus.o_valid), 32'd1);
    chk("neg1_res",   32'(bus.o_res), 32'b101);
    chk("neg1_op",    32'(bus.o_op), 32'd4);
    chk("neg1_flags", 32'({bus.o_SF, bus.o_ZF, bus.o_DZF}), 32'b100);
    chk("neg1_count", 32'(bus.o_count), 32'd1);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("pop1_count", 32'(bus.o_count), 32'd0);
    chk("pop1_res",   32'(bus.o_res), 32'd0);

    // Negative zero with a consistent zero flag
    drive(1'b1, 3'd1, 3'b100, 1'b0, 1'b1);
    tick();
    chk("nz_res",      32'(bus.o_res), 32'd0);
    chk("nz_flags",    32'({bus.o_SF, bus.o_ZF}), 32'b01);
    chk("nz_mismatch", 32'(bus.o_flag_mismatch), 32'd0);
    // Same value, inconsistent zero flag
    drive(1'b1, 3'd1, 3'b100, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("nz2_mismatch", 32'(bus.o_flag_mismatch), 32'd1);
    chk("nz2_count",    32'(bus.o_count), 32'd2);
    bus.i_clr_sticky = 1'b1;
    tick();
    bus.i_clr_sticky = 1'b0;
    chk("clr_mismatch", 32'(bus.o_flag_mismatch), 32'd0);
    bus.i_ready = 1'b1;
    tick(); tick();
    bus.i_ready = 1'b0;
    chk("drain2_count", 32'(bus.o_count), 32'd0);

    // Fill past DEPTH with reserved opcodes mixed in
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'(k + 3), fill_res[k], 1'b0, 1'b0);
      if (k < 4) exp_q.push_back(fill_res[k]);
      tick();
      chk($sformatf("fill%0d_count", k), 32'(bus.o_count), (k < 4) ? 32'(k + 1) : 32'd4);
      chk($sformatf("fill%0d_ready", k), 32'(bus.o_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("fill_head_op", 32'(bus.o_op), 32'd3);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_res", k), 32'(bus.o_res), 32'(exp_q.pop_front()));
      tick();
      chk($sformatf("drain%0d_ready", k), 32'(bus.o_ready), 32'd1);
    end
    bus.i_ready = 1'b0;
    chk("drain_empty", 32'(bus.o_valid), 32'd0);

    // Divide-by-zero entries
    drive(1'b1, 3'd3, 3'b110, 1'b1, 1'b0); tick();
    drive(1'b1, 3'd3, 3'b000, 1'b1, 1'b1); tick();
    drive(1'b1, 3'd3, 3'b110, 1'b1, 1'b0); tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("dz_err",      32'(bus.o_err_cnt), 32'd3);
    chk("dz_sticky",   32'(bus.o_sticky_DZ), 32'd1);
    chk("dz_mismatch", 32'(bus.o_flag_mismatch), 32'd0);
    exp_q.push_back(3'b110); exp_q.push_back(3'b000); exp_q.push_back(3'b110);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dz%0d_dzf", k), 32'(bus.o_DZF), 32'd1);
      chk($sformatf("dz%0d_res", k), 32'(bus.o_res), 32'(exp_q.pop_front()));
      tick();
    end
    bus.i_ready = 1'b0;

    // Clear coinciding with a DZ push: set wins
    drive(1'b1, 3'd3, 3'b011, 1'b1, 1'b0);
    bus.i_clr_sticky = 1'b1;
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("clrdz_sticky", 32'(bus.o_sticky_DZ), 32'd1);
    chk("clrdz_err",    32'(bus.o_err_cnt), 32'd1);
    tick();
    bus.i_clr_sticky = 1'b0;
    chk("clr_sticky", 32'(bus.o_sticky_DZ), 32'd0);
    chk("clr_err",    32'(bus.o_err_cnt), 32'd0);

    // Counter saturation with simultaneous push and pop
    drive(1'b1, 3'd4, 3'b011, 1'b1, 1'b0);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    chk("pp_count", 32'(bus.o_count), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(); tick();
    chk("sat_err",   32'(bus.o_err_cnt), 32'd255);
    chk("sat_count", 32'(bus.o_count), 32'd0);
    bus.i_ready = 1'b0;
    bus.i_clr_sticky = 1'b1;
    tick();
    bus.i_clr_sticky = 1'b0;

    // Asynchronous reset while draining
    drive(1'b1, 3'd3, 3'b010, 1'b1, 1'b0); tick(); tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.o_count), 32'd2);
    chk("pre_rst_err",   32'(bus.o_err_cnt), 32'd2);
    bus.i_ready = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_ready", 32'(bus.o_ready), 32'd1);
    chk("arst_count", 32'(bus.o_count), 32'd0);
    chk("arst_err",   32'(bus.o_err_cnt), 32'd0);
    chk("arst_res",   32'(bus.o_res), 32'd0);
    tick();
    i_rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(bus.o_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
